top: RTL and testbench
======================

// Module: top
// PURPOSE
//   Fully pipelined unsigned 4x4 -> 8-bit multiplier for low-power analysis.
//   One partial product (PP) is added per stage, with no shared or common
//   hardware. Accepts a new operand pair every clock and returns one product
//   per clock after a fixed latency.
//   Sits at the top of the multiplier test design, driven directly by the
//   stimulus bench.
// PARAMETERS
//   WIDTH    4   operand width in bits; the product is 2*WIDTH bits
//   LATENCY  4   number of register stages from the input sample to result
//                (fixed at WIDTH)
// PORTS
//   clk     in   1        single clock; all state updates on the rising edge
//   rst     in   1        asynchronous, active-low reset
//   x       in   WIDTH    multiplicand, unsigned
//   y       in   WIDTH    multiplier, unsigned
//   result  out  2*WIDTH  product x*y, registered output
// BEHAVIOUR
//   - Reset: rst low clears every pipeline register immediately, without
//     waiting for clk. result reads 8'h00 while rst is low.
//   - After rst deasserts, operation starts at the next rising edge.
//   - Stage 0 (edge N):
//       - capture x and y;
//       - acc0 = y[0] ? {4'b0,x} : 0.
//   - Stage k, k = 1..3 (edge N+k):
//       - acc_k = acc_{k-1} + (y[k] ? x<<k : 0);
//       - the x and y copies are forwarded with the data.
//   - The stage-3 register drives result.
//   - Timing: x and y sampled at edge N appear on result after edge N+3,
//     i.e. 4 register stages.
//   - Throughput: 1 result per cycle. No handshake and no stall; the
//     pipeline always advances.
//   - Arithmetic: unsigned, 8-bit accumulators, no overflow possible.
//     Maximum is 15*15 = 225.
//   - Operands held constant for M cycles give a constant result for
//     M cycles after the latency.
//   - Back-to-back changes each cycle give one distinct product per cycle,
//     with no mixing between stages.
//   - Reset asserted mid-operation: all in-flight products are discarded.
//     After release the output stays 0 until new operands have propagated
//     through (up to 4 edges).
//   - Outputs have no X after reset; no combinational path from input to
//     result.
// STRUCTURE
//   - Shared package mult_pkg holds:
//       - localparam WIDTH = 4;
//       - localparam PW = 2*WIDTH;
//       - typedef logic [WIDTH-1:0] opnd_t;
//       - typedef logic [PW-1:0] prod_t.
//   - Sub-module mult_pp_stage, instantiated WIDTH times with a parameter
//     STAGE:
//       - registers opnd_t x, y and prod_t acc;
//       - adds the shifted PP selected by y[STAGE];
//       - has its own async active-low reset.
//   - top instantiates a generate chain of mult_pp_stage and connects
//     result to the last acc.
// TESTING
//   - Reset:
//       - hold rst=0 with x=15, y=15 -> result == 0 throughout;
//       - release -> result = 225 on the 4th edge after release.
//   - Latency:
//       - x=3, y=7 applied before edge N -> result = 21 after edge N+3
//         and not earlier.
//   - Sequence:
//       - (1,9) (2,8) (3,7) (4,6) (5,5) (6,4) (7,3) (8,2) (9,1), each held
//         7 cycles -> 9,16,21,24,25,24,21,16,9, each lasting 7 cycles;
//       - no glitch values in between.
//   - Throughput:
//       - a new pair every cycle, (0,0) (15,1) (1,15) (15,15) (10,12)
//         -> consecutive results 0, 15, 15, 225, 120.
//   - Zero/identity:
//       - x=0, y=13 gives 0;
//       - x=13, y=1 gives 13;
//       - x=8, y=8 gives 64.
//   - Mid-stream reset:
//       - pulse rst low asynchronously between edges -> result goes to 0
//         immediately;
//       - after release, only post-reset operands appear.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared widths and types for the pipelined 4x4 multiplier.
//                WIDTH - operand width; PW - product width (2*WIDTH);
//                opnd_t - one operand; prod_t - one product / accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;

    typedef logic [WIDTH-1:0] opnd_t;
    typedef logic [PW-1:0]    prod_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_pp_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pp_stage
//  Description : One multiplier pipeline stage. Adds the partial product
//                selected by y[STAGE] (x shifted left by STAGE) to the
//                incoming accumulator and registers the operands alongside
//                the new sum so they travel with their own data.
//  Ports       : clk            - rising-edge clock
//                rst            - asynchronous, active-low reset
//                x_d, y_d       - operands from the previous stage
//                acc_d          - accumulator from the previous stage
//                x_q, y_q       - registered operands forwarded onward
//                acc_q          - registered accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  opnd_t x_d,
    input  opnd_t y_d,
    input  prod_t acc_d,
    output opnd_t x_q,
    output opnd_t y_q,
    output prod_t acc_q
);

    opnd_t r_x;
    opnd_t r_y;
    prod_t r_acc;
    prod_t w_pp;

    // Widen before shifting so the top bits of x are not lost.
    assign w_pp = y_d[STAGE] ? (prod_t'(x_d) << STAGE) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
        end else begin
            r_x   <= x_d;
            r_y   <= y_d;
            r_acc <= acc_d + w_pp;
        end
    end

    assign x_q   = r_x;
    assign y_q   = r_y;
    assign acc_q = r_acc;

endmodule : mult_pp_stage
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
//  Module      : top
//  Description : Fully pipelined unsigned WIDTH x WIDTH multiplier. One
//                partial product is added per stage; a new operand pair is
//                accepted every clock and its product appears on result
//                WIDTH register stages later.
//  Ports       : clk    - rising-edge clock
//                rst    - asynchronous, active-low reset
//                x      - multiplicand, unsigned
//                y      - multiplier, unsigned
//                result - registered product x*y
//  Revision    : 1.0 - initial release
// ============================================================================
module top
    import mult_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  opnd_t x,
    input  opnd_t y,
    output prod_t result
);

    localparam int LATENCY = WIDTH;

    // Index k carries the values entering stage k; index LATENCY is the
    // output of the last stage.
    opnd_t x_s   [0:LATENCY];
    opnd_t y_s   [0:LATENCY];
    prod_t acc_s [0:LATENCY];

    assign x_s[0]   = x;
    assign y_s[0]   = y;
    assign acc_s[0] = '0;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        mult_pp_stage #(
            .STAGE (k)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .x_d   (x_s[k]),
            .y_d   (y_s[k]),
            .acc_d (acc_s[k]),
            .x_q   (x_s[k+1]),
            .y_q   (y_s[k+1]),
            .acc_q (acc_s[k+1])
        );
    end

    // The operands forwarded out of the last stage have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = ^{x_s[LATENCY], y_s[LATENCY]};

    assign result = acc_s[LATENCY];

endmodule : top
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_top
//  Description : Scoreboard bench for the pipelined multiplier. A producer
//                records x*y with the clock count at which the product is
//                due every edge the pipeline is out of reset; a monitor
//                compares result on each falling edge against the due
//                entry, or against zero when nothing is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

    logic       clk;
    logic       rst;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t q[$];

    top dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .y      (y),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Producer: an operand pair sampled at edge N is due after edge N+3.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst === 1'b1) begin
            q.push_back('{due: cyc + 3, val: int'(x) * int'(y)});
        end
    end

    // In-flight products are discarded the instant reset asserts.
    always @(negedge rst) q.delete();

    // Monitor.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            check("reset_zero", int'(result), 0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            check("product", int'(result), e.val);
        end else begin
            check("idle_zero", int'(result), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int a, input int b, input int n);
        x = 4'(a);
        y = 4'(b);
        repeat (n) tick();
    endtask

    initial begin
        int seq_x [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int seq_y [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        int tp_x  [5] = '{0, 15, 1, 15, 10};
        int tp_y  [5] = '{0, 1, 15, 15, 12};

        rst = 1'b0;
        x   = 4'd15;
        y   = 4'd15;
        repeat (5) tick();
        check("held_reset", int'(result), 0);

        // Release between edges; 225 is expected on the 4th edge after.
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) tick();
        check("pre_latency_zero", int'(result), 0);
        tick();
        check("first_225", int'(result), 225);
        apply(15, 15, 2);

        apply(3, 7, 6);

        for (int i = 0; i < 9; i++) apply(seq_x[i], seq_y[i], 7);

        for (int i = 0; i < 5; i++) apply(tp_x[i], tp_y[i], 1);

        apply(0, 13, 3);
        apply(13, 1, 3);
        apply(8, 8, 3);

        for (int i = 0; i < 100; i++) apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);

        // Mid-stream asynchronous reset pulse.
        x = 4'd15;
        y = 4'd15;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_clear", int'(result), 0);
        repeat (2) tick();
        @(posedge clk);
        #3;
        rst = 1'b1;

        for (int i = 0; i < 100; i++) apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);

        apply(0, 0, 4);
        @(negedge clk);
        #1;
        check("in_flight_count", q.size(), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d: got running, expected finished", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule : tb_top
`default_nettype wire
